md_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds the HI/LO registers. It produces `stall_md`, which the D→E pipeline register consumes to insert a bubble while an MD-class instruction waits in D. It also drops E-stage issues that coincide with an interrupt or exception.

---
 rtl/md_unit.sv | 130 +++++++++++++
 tb/tb_md_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit for the EX stage, owns the HI/LO registers.
// Latency: mult/multu take MULT_CYCLES busy cycles, div/divu take DIV_CYCLES; mthi/mtlo update HI/LO at the issue edge.
// Backpressure: issues arriving while busy are dropped; stall_md holds MD-class instructions in D while busy or issuing.
// Ports: clk, reset (async active-low), start/op/A/B issue from E, cancel (IntReq|ExcReq),
//        md_D (D-stage MD-class instruction), busy/HI/LO registered, stall_md combinational.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        md_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic          nowr_q, nowr_d;   // divide by zero: complete without touching HI/LO

  logic          accept;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   b_safe, sq, sr, uq, ur;
  logic          ovf;

  assign accept = start & ~cancel & ~busy_q;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // A zero divisor is replaced so the divider never produces X; the result is discarded anyway.
  assign b_safe = (B == 32'd0) ? 32'd1 : B;
  // -2^31 / -1 overflows 32 bits; pin the architectural result explicitly.
  assign ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign sq     = ovf ? 32'h8000_0000 : $unsigned($signed(A) / $signed(b_safe));
  assign sr     = ovf ? 32'd0         : $unsigned($signed(A) % $signed(b_safe));
  assign uq     = A / b_safe;
  assign ur     = A % b_safe;

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    nowr_d    = nowr_q;

    if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        if (!nowr_q) begin
          hi_d = hi_pend_q;
          lo_d = lo_pend_q;
        end
      end
    end else if (accept) begin
      case (op)
        3'd0: begin
          {hi_pend_d, lo_pend_d} = prod_s;
          nowr_d = 1'b0;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        3'd1: begin
          {hi_pend_d, lo_pend_d} = prod_u;
          nowr_d = 1'b0;
          cnt_d  = CW'(MULT_CYCLES);
          busy_d = 1'b1;
        end
        3'd2: begin
          hi_pend_d = sr;
          lo_pend_d = sq;
          nowr_d    = (B == 32'd0);
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        3'd3: begin
          hi_pend_d = ur;
          lo_pend_d = uq;
          nowr_d    = (B == 32'd0);
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        3'd4:    hi_d = A;
        3'd5:    lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      nowr_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      nowr_q    <= nowr_d;
    end
  end

  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign stall_md = md_D & (busy_q | (start & ~op[2] & ~cancel));

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk, reset, start, cancel, md_D;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_md;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .md_D(md_D), .busy(busy), .HI(HI), .LO(LO), .stall_md(stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one issue in the cycle before an edge; return after that edge (+1).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic md);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; cancel = c; md_D = md;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0; md_D = 1'b0;
  endtask

  // Count busy cycles after the issue edge, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operand values.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     pv, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nb = 0;
    case (o)
      3'd0: begin pv = sa * sb; m_hi = pv[63:32]; m_lo = pv[31:0]; nb = 5; end
      3'd1: begin p = ua * ub; pv = p; m_hi = pv[63:32]; m_lo = pv[31:0]; nb = 5; end
      3'd2: begin
        nb = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          m_lo = qv[31:0]; m_hi = rv[31:0];
        end
      end
      3'd3: begin
        nb = 10;
        if (b != 0) begin
          qv = ua / ub; rv = ua % ub;
          m_lo = qv[31:0]; m_hi = rv[31:0];
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int n, nb;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd5, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 0};
    vecs[4] = '{3'd2, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 10};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[6] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10};
    vecs[7] = '{3'd4, 32'hCAFE_F00D, 32'd7,        32'hCAFE_F00D, 32'h7FFF_FFFC, 0};
    vecs[8] = '{3'd6, 32'h1111_1111, 32'd9,        32'hCAFE_F00D, 32'h7FFF_FFFC, 0};

    start = 0; op = 0; A = 0; B = 0; cancel = 0; md_D = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    md_D = 1'b1; #1;
    chk("reset_stall", stall_md, 0);
    md_D = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", busy, 0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = 1'b1; op = vecs[i].op; A = vecs[i].a; B = vecs[i].b; md_D = 1'b1;
      #1;
      chk($sformatf("vec%0d_issue_stall", i), stall_md, (vecs[i].op <= 3) ? 1 : 0);
      @(posedge clk); #1;
      start = 1'b0; md_D = 1'b0;
      wait_done(n);
      chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].exp_busy);
      chk($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
    end
    m_hi = 32'hCAFE_F00D;
    m_lo = 32'h7FFF_FFFC;

    // Cancel: issue dropped, no stall even with an MD op in D
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd100; B = 32'd100; cancel = 1'b1; md_D = 1'b1;
    #1;
    chk("cancel_stall", stall_md, 0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; md_D = 1'b0;
    chk("cancel_busy", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("cancel_hi", HI, m_hi);
    chk("cancel_lo", LO, m_lo);

    // Busy window: mthi during a mult is ignored, stall held
    issue(3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF; md_D = 1'b1;
    #1;
    chk("busy_stall", stall_md, 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_mthi_ignored", HI, m_hi);
    wait_done(n);
    chk("busy_hi", HI, 0);
    chk("busy_lo", LO, 32'd12);
    chk("stall_drop", stall_md, 0);
    md_D = 1'b0;
    m_hi = 0; m_lo = 32'd12;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, nb);
      issue(ro, ra, rb, 1'b0, 1'b0);
      wait_done(n);
      chk($sformatf("rnd%0d_op%0d_busy", i, ro), n, nb);
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), HI, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), LO, m_lo);
    end

    // Asynchronous reset mid-div discards the result
    issue(3'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_post_busy", busy, 0);
    chk("arst_post_hi", HI, 0);
    chk("arst_post_lo", LO, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
